// File: rtl/dram_rd_pkg.sv
// dram_rd_pkg: shared FSM states, AXI burst/response codes and request checks
// for the dram_rd_slave read slave.
package dram_rd_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_64B    = 3'd3;

    // Only full 64-bit beats with FIXED or INCR bursts are served.
    function automatic logic is_bad_req(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_64B) || burst[1];
    endfunction

endpackage

// File: rtl/dram_rd_mem.sv
// dram_rd_mem: 2^ADDR_W x 64 storage, synchronous read, backdoor write port.
// Read-before-write: a same-cycle read and write to one address returns the old word.
module dram_rd_mem #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [63:0]       wdata,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    output logic [63:0]       rdata
);

    logic [63:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wen)
            mem[waddr] <= wdata;
        if (ren)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/dram_rd_slave.sv
// dram_rd_slave: single-outstanding AXI-style read slave (IDLE/FETCH/VALID).
// Define DRAM_RD_BACKDOOR_EN for real storage with bd_* ports; otherwise data is address-derived.
module dram_rd_slave
    import dram_rd_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_axi_arvld,
    input  logic [7:0]        lsu_axi_arid,
    input  logic [ADDR_W-1:0] lsu_axi_araddr,
    input  logic [7:0]        lsu_axi_arlen,
    input  logic [2:0]        lsu_axi_arsize,
    input  logic [1:0]        lsu_axi_arburst,
    input  logic [2:0]        lsu_axi_arstr,
    output logic              axi_lsu_arrdy,
    output logic              axi_lsu_rvld,
    output logic [7:0]        axi_lsu_rid,
    output logic [63:0]       axi_lsu_rdata,
    output logic [1:0]        axi_lsu_rresp,
    output logic              axi_lsu_rlast,
`ifdef DRAM_RD_BACKDOOR_EN
    input  logic              bd_wen,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [63:0]       bd_wdata,
`endif
    input  logic              lsu_axi_rrdy
);

    state_t            state_q, state_d;
    logic [7:0]        id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        burst_q, burst_d;
    logic [2:0]        str_q, str_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] step;
    logic [63:0]       beat_data;

    assign step = (burst_q == BURST_INCR) ? (ADDR_W'(1) << str_q) : '0;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        str_d   = str_q;
        err_d   = err_q;
        if (axi_lsu_arrdy && lsu_axi_arvld) begin
            state_d = FETCH;
            id_d    = lsu_axi_arid;
            addr_d  = lsu_axi_araddr;
            cnt_d   = lsu_axi_arlen;
            burst_d = lsu_axi_arburst;
            str_d   = lsu_axi_arstr;
            err_d   = is_bad_req(lsu_axi_arsize, lsu_axi_arburst);
        end else if (state_q == FETCH) begin
            state_d = VALID;
        end else if (state_q == VALID && lsu_axi_rrdy) begin
            state_d = (cnt_q == 8'd0) ? IDLE : FETCH;
            cnt_d   = cnt_q - 8'd1;
            addr_d  = addr_q + step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            burst_q <= BURST_FIXED;
            str_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            str_q   <= str_d;
            err_q   <= err_d;
        end
    end

`ifdef DRAM_RD_BACKDOOR_EN
    dram_rd_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .wen   (bd_wen),
        .waddr (bd_addr),
        .wdata (bd_wdata),
        .ren   (state_q == FETCH && !err_q),
        .raddr (addr_q),
        .rdata (beat_data)
    );
`else
    assign beat_data = {~32'(addr_q), 32'(addr_q)};
`endif

    // rst gates arrdy directly so it drops the moment reset is asserted.
    assign axi_lsu_arrdy = (state_q == IDLE) && !rst;
    assign axi_lsu_rvld  = (state_q == VALID);
    assign axi_lsu_rid   = id_q;
    assign axi_lsu_rresp = (axi_lsu_rvld && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign axi_lsu_rlast = axi_lsu_rvld && (cnt_q == 8'd0);
    assign axi_lsu_rdata = (axi_lsu_rvld && !err_q) ? beat_data : '0;

endmodule

// File: tb/tb_dram_rd_slave.sv
// tb_dram_rd_slave: directed self-checking bench for dram_rd_slave (ADDR_W=10).
// With DRAM_RD_BACKDOOR_EN the storage is preloaded with the address-derived pattern first.
module tb_dram_rd_slave;
    import dram_rd_pkg::*;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          arvld;
    logic [7:0]    arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [2:0]    arstr;
    logic          arrdy;
    logic          rvld;
    logic [7:0]    rid;
    logic [63:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rrdy;
`ifdef DRAM_RD_BACKDOOR_EN
    logic          bd_wen;
    logic [AW-1:0] bd_addr;
    logic [63:0]   bd_wdata;
`endif

    int n_chk = 0;
    int n_fail = 0;

    wire [75:0] obs = {rvld, rlast, rresp, rid, rdata};
    logic [75:0] exp_v;

    always #5 clk = ~clk;

    dram_rd_slave #(.ADDR_W(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .lsu_axi_arvld   (arvld),
        .lsu_axi_arid    (arid),
        .lsu_axi_araddr  (araddr),
        .lsu_axi_arlen   (arlen),
        .lsu_axi_arsize  (arsize),
        .lsu_axi_arburst (arburst),
        .lsu_axi_arstr   (arstr),
        .axi_lsu_arrdy   (arrdy),
        .axi_lsu_rvld    (rvld),
        .axi_lsu_rid     (rid),
        .axi_lsu_rdata   (rdata),
        .axi_lsu_rresp   (rresp),
        .axi_lsu_rlast   (rlast),
`ifdef DRAM_RD_BACKDOOR_EN
        .bd_wen          (bd_wen),
        .bd_addr         (bd_addr),
        .bd_wdata        (bd_wdata),
`endif
        .lsu_axi_rrdy    (rrdy)
    );

    function automatic logic [63:0] pat(input logic [AW-1:0] a);
        return {~{22'd0, a}, {22'd0, a}};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ar(input logic [7:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [2:0] str);
        arvld = 1'b1; arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arstr = str;
    endtask

    task automatic test_reset;
        rst = 1'b1; arvld = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = SIZE_64B;
        arburst = BURST_INCR; arstr = '0; rrdy = 1'b1;
`ifdef DRAM_RD_BACKDOOR_EN
        bd_wen = 1'b0; bd_addr = '0; bd_wdata = '0;
`endif
        #1;
        n_chk++;
        if ({arrdy, obs} !== 77'd0) begin
            n_fail++; $display("FAIL reset_outputs got %h exp %h", {arrdy, obs}, 77'd0);
        end
        tick; tick;
        rst = 1'b0;
        #1;
        n_chk++;
        if ({arrdy, rvld} !== 2'b10) begin
            n_fail++; $display("FAIL reset_release arrdy,rvld got %b exp 10", {arrdy, rvld});
        end
    endtask

`ifdef DRAM_RD_BACKDOOR_EN
    task automatic preload;
        for (int a = 0; a < 2**AW; a++) begin
            bd_wen = 1'b1; bd_addr = AW'(a); bd_wdata = pat(AW'(a));
            tick;
        end
        for (int i = 0; i < 4; i++) begin
            bd_addr = AW'(10'h010 + i); bd_wdata = 64'h11 * (i + 1);
            tick;
        end
        bd_wen = 1'b0;
    endtask

    task automatic test_backdoor;
        logic [63:0] e [4];
        e = '{64'h11, 64'h22, 64'h33, 64'h44};
        drive_ar(8'h5A, 10'h010, 8'd3, SIZE_64B, BURST_INCR, 3'd0);
        tick;
        arvld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (rvld !== 1'b0) begin
                n_fail++; $display("FAIL bd_fetch%0d rvld got %b exp 0", i, rvld);
            end
            if (i == 1) begin
                bd_wen = 1'b1; bd_addr = 10'h011; bd_wdata = 64'hDEAD;
            end
            tick;
            bd_wen = 1'b0;
            exp_v = {1'b1, (i == 3), RESP_OKAY, 8'h5A, e[i]};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL bd_beat%0d got %h exp %h", i, obs, exp_v);
            end
            tick;
        end
    endtask
`endif

    task automatic test_wrap;
        logic [63:0] e [3];
        e = '{64'hFFFFFC01_000003FE, 64'hFFFFFFFF_00000000, 64'hFFFFFFFD_00000002};
        drive_ar(8'h33, 10'h3FE, 8'd2, SIZE_64B, BURST_INCR, 3'd1);
        n_chk++;
        if (arrdy !== 1'b1) begin
            n_fail++; $display("FAIL wrap_arrdy got %b exp 1", arrdy);
        end
        tick;
        arvld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (rvld !== 1'b0) begin
                n_fail++; $display("FAIL wrap_fetch%0d rvld got %b exp 0", i, rvld);
            end
            tick;
            exp_v = {1'b1, (i == 2), RESP_OKAY, 8'h33, e[i]};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL wrap_beat%0d got %h exp %h", i, obs, exp_v);
            end
            tick;
        end
        n_chk++;
        if ({arrdy, rvld} !== 2'b10) begin
            n_fail++; $display("FAIL wrap_idle arrdy,rvld got %b exp 10", {arrdy, rvld});
        end
    endtask

    task automatic test_fixed;
        drive_ar(8'h07, 10'h100, 8'd1, SIZE_64B, BURST_FIXED, 3'd2);
        tick;
        arvld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            exp_v = {1'b1, (i == 1), RESP_OKAY, 8'h07, 64'hFFFFFEFF_00000100};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL fixed_beat%0d got %h exp %h", i, obs, exp_v);
            end
            tick;
        end
    endtask

    task automatic test_error;
        drive_ar(8'hE1, 10'h200, 8'd1, 3'd2, BURST_INCR, 3'd0);
        tick;
        arvld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            exp_v = {1'b1, (i == 1), RESP_SLVERR, 8'hE1, 64'd0};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL err_size_beat%0d got %h exp %h", i, obs, exp_v);
            end
            tick;
        end
        drive_ar(8'h0C, 10'h123, 8'd0, SIZE_64B, 2'b11, 3'd0);
        tick;
        arvld = 1'b0;
        tick;
        exp_v = {1'b1, 1'b1, RESP_SLVERR, 8'h0C, 64'd0};
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++; $display("FAIL err_burst_beat got %h exp %h", obs, exp_v);
        end
        tick;
        n_chk++;
        if ({arrdy, rvld} !== 2'b10) begin
            n_fail++; $display("FAIL err_idle arrdy,rvld got %b exp 10", {arrdy, rvld});
        end
    endtask

    task automatic test_backpressure;
        drive_ar(8'h5B, 10'h020, 8'd1, SIZE_64B, BURST_INCR, 3'd0);
        tick;
        drive_ar(8'h99, 10'h0AB, 8'd0, SIZE_64B, BURST_INCR, 3'd0);
        rrdy = 1'b0;
        tick;
        for (int c = 0; c < 5; c++) begin
            n_chk++;
            if ({arrdy, obs} !== {1'b0, 1'b1, 1'b0, RESP_OKAY, 8'h5B, 64'hFFFFFFDF_00000020}) begin
                n_fail++; $display("FAIL bp_hold%0d got %h", c, {arrdy, obs});
            end
            tick;
        end
        rrdy = 1'b1;
        tick;
        n_chk++;
        if ({arrdy, rvld} !== 2'b00) begin
            n_fail++; $display("FAIL bp_fetch1 arrdy,rvld got %b exp 00", {arrdy, rvld});
        end
        tick;
        n_chk++;
        if ({arrdy, obs} !== {1'b0, 1'b1, 1'b1, RESP_OKAY, 8'h5B, 64'hFFFFFFDE_00000021}) begin
            n_fail++; $display("FAIL bp_beat1 got %h", {arrdy, obs});
        end
        tick;
        n_chk++;
        if ({arrdy, rvld} !== 2'b10) begin
            n_fail++; $display("FAIL bp_idle arrdy,rvld got %b exp 10", {arrdy, rvld});
        end
        tick;
        arvld = 1'b0;
        tick;
        exp_v = {1'b1, 1'b1, RESP_OKAY, 8'h99, 64'hFFFFFF54_000000AB};
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++; $display("FAIL bp_second got %h exp %h", obs, exp_v);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        drive_ar(8'h21, 10'h040, 8'd7, SIZE_64B, BURST_INCR, 3'd0);
        tick;
        arvld = 1'b0;
        tick;
        tick;
        tick;
        exp_v = {1'b1, 1'b0, RESP_OKAY, 8'h21, 64'hFFFFFFBE_00000041};
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++; $display("FAIL rstmid_beat1 got %h exp %h", obs, exp_v);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({arrdy, obs} !== 77'd0) begin
            n_fail++; $display("FAIL rstmid_assert got %h exp 0", {arrdy, obs});
        end
        tick;
        rst = 1'b0;
        #1;
        n_chk++;
        if ({arrdy, rvld} !== 2'b10) begin
            n_fail++; $display("FAIL rstmid_release arrdy,rvld got %b exp 10", {arrdy, rvld});
        end
        tick;
        tick;
        n_chk++;
        if ({arrdy, rvld} !== 2'b10) begin
            n_fail++; $display("FAIL rstmid_no_beats arrdy,rvld got %b exp 10", {arrdy, rvld});
        end
        drive_ar(8'h3C, 10'h055, 8'd0, SIZE_64B, BURST_INCR, 3'd0);
        tick;
        arvld = 1'b0;
        tick;
        exp_v = {1'b1, 1'b1, RESP_OKAY, 8'h3C, 64'hFFFFFFAA_00000055};
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++; $display("FAIL rstmid_next got %h exp %h", obs, exp_v);
        end
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
`ifdef DRAM_RD_BACKDOOR_EN
        preload;
        test_backdoor;
`endif
        test_wrap;
        test_fixed;
        test_error;
        test_backpressure;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
